// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT framing logic (input-side sender and
// output-side sample counter).
package fft_pkg;

  localparam int SAMPLES = 2048;
  localparam int SIZE    = 32;
  localparam int ADDR_W  = $clog2(SAMPLES);

  typedef logic [SIZE-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sender_state_e;

  // Output FIFO depth: every read in flight needs a landing slot, plus slack.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/fft_frame_sender_chk.sv
// Simulation-only properties for the sender's credit/FIFO bookkeeping.
module fft_frame_sender_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push,
  input logic             pop,
  input logic             full,
  input logic [CNT_W-1:0] credits,
  input logic [CNT_W-1:0] count
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(credits) + int'(count)) <= DEPTH);

endmodule

// File: rtl/fft_sync_fifo.sv
// Synchronous FIFO with flush; one push and one pop per cycle, head word on dout.
module fft_sync_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 32,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push & (~full | pop);
  assign pop_ok_s  = pop & ~empty;

  // Storage has no reset: a slot is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy update; flush discards everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_sender.sv
// Input-side FFT framer: streams SAMPLES words from the sample RAM to the FFT core,
// flagging sample 0 with fft_sync; a credit-limited FIFO absorbs read latency and stalls.
module fft_frame_sender #(
  parameter int  SAMPLES = fft_pkg::SAMPLES,
  parameter int  SIZE    = fft_pkg::SIZE,
  parameter int  RD_LAT  = 2,
  localparam int ADDR_W  = $clog2(SAMPLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [SIZE-1:0]   rd_data,
  output logic              fft_valid,
  input  logic              fft_ready,
  output logic              fft_sync,
  output logic [SIZE-1:0]   fft_data
);

  import fft_pkg::*;

  localparam int                FIFO_DEPTH = fifo_depth(RD_LAT);
  localparam int                CR_W       = $clog2(FIFO_DEPTH + 1);
  localparam logic [CR_W-1:0]   CR_FULL    = CR_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(SAMPLES - 1);

  sender_state_e     state_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [ADDR_W-1:0] sent_r;
  logic [CR_W-1:0]   credits_r;
  logic [RD_LAT-1:0] vld_sr_r;
  logic              done_r;

  logic              rd_en_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CR_W-1:0]   fifo_count_s;
  logic [SIZE-1:0]   fifo_dout_s;

  // A read is only issued when a FIFO slot is already reserved for its data.
  assign rd_en_s = (state_r == RUN) && (credits_r != {CR_W{1'b0}}) && !fifo_full_s;
  assign push_s  = vld_sr_r[RD_LAT-1];
  assign pop_s   = !fifo_empty_s && fft_ready;

  fft_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SIZE)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (push_s),
    .pop   (pop_s),
    .din   (rd_data),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  fft_frame_sender_chk #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CR_W)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .pop     (pop_s),
    .full    (fifo_full_s),
    .credits (credits_r),
    .count   (fifo_count_s)
  );

  // Frame FSM, address/sent counters, credit counter and read-valid pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rd_addr_r <= {ADDR_W{1'b0}};
      sent_r    <= {ADDR_W{1'b0}};
      credits_r <= CR_FULL;
      vld_sr_r  <= {RD_LAT{1'b0}};
      done_r    <= 1'b0;
    end else if (clr) begin
      state_r   <= IDLE;
      rd_addr_r <= {ADDR_W{1'b0}};
      sent_r    <= {ADDR_W{1'b0}};
      credits_r <= CR_FULL;
      vld_sr_r  <= {RD_LAT{1'b0}};
      done_r    <= 1'b0;
    end else begin
      vld_sr_r  <= RD_LAT'({vld_sr_r, rd_en_s});
      credits_r <= credits_r - CR_W'(rd_en_s) + CR_W'(pop_s);
      done_r    <= 1'b0;
      if (pop_s) begin
        sent_r <= sent_r + ADDR_W'(1);
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= RUN;
            rd_addr_r <= {ADDR_W{1'b0}};
            sent_r    <= {ADDR_W{1'b0}};
          end
        end
        RUN: begin
          if (rd_en_s) begin
            if (rd_addr_r == LAST_ADDR) begin
              state_r <= DRAIN;
            end else begin
              rd_addr_r <= rd_addr_r + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (pop_s && (sent_r == LAST_ADDR)) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r   <= IDLE;
          rd_addr_r <= {ADDR_W{1'b0}};
          sent_r    <= {ADDR_W{1'b0}};
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_r != IDLE);
  assign done      = done_r;
  assign rd_en     = rd_en_s;
  assign rd_addr   = rd_addr_r;
  assign fft_valid = !fifo_empty_s;
  assign fft_sync  = !fifo_empty_s && (sent_r == {ADDR_W{1'b0}});
  assign fft_data  = fifo_empty_s ? {SIZE{1'b0}} : fifo_dout_s;

endmodule

// File: tb/tb_fft_frame_sender.sv
// Scoreboard bench for fft_frame_sender: random RAM contents and ready patterns,
// expected beats queued at start and popped by an independent output monitor.
module tb_fft_frame_sender;

  localparam int SAMPLES = 16;
  localparam int SIZE    = 32;
  localparam int RD_LAT  = 2;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = RD_LAT + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              clr = 1'b0;
  logic              fft_ready = 1'b0;
  logic              busy, done, rd_en, fft_valid, fft_sync;
  logic [ADDR_W-1:0] rd_addr;
  logic [SIZE-1:0]   rd_data = '0;
  logic [SIZE-1:0]   fft_data;

  typedef struct packed {
    logic [SIZE-1:0] data;
    logic            sync;
  } beat_t;

  logic [SIZE-1:0] ram  [SAMPLES];
  logic [SIZE-1:0] pipe [RD_LAT+1];
  beat_t           exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int reads = 0;
  int accepted = 0;
  int start_cyc = 0;
  int abort_gen = 0;
  int stall_gen = 0;
  int done_count = 0;
  bit model_busy = 1'b0;
  bit first_pending = 1'b0;
  bit done_seen = 1'b0;
  bit time_done = 1'b0;
  bit stall_prev = 1'b0;
  logic [SIZE-1:0] prev_data;
  logic            prev_sync;

  fft_frame_sender #(
    .SAMPLES (SAMPLES),
    .SIZE    (SIZE),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clr       (clr),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .fft_valid (fft_valid),
    .fft_ready (fft_ready),
    .fft_sync  (fft_sync),
    .fft_data  (fft_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // RAM with RD_LAT cycles of read latency; garbage on rd_data when no read is due.
  initial forever begin
    @(negedge clk);
    for (int i = RD_LAT; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = rd_en ? ram[rd_addr] : $urandom();
    rd_data = pipe[RD_LAT];
  end

  // fft_ready pattern: 0 = always, 1 = random 50%, 2 = held low.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       fft_ready = 1'b1;
      1:       fft_ready = 1'($urandom_range(0, 1));
      default: fft_ready = 1'b0;
    endcase
  end

  // Output monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (stall_prev && stall_gen == abort_gen) begin
        chk("stall_valid", fft_valid, 1);
        chk("stall_data", fft_data, prev_data);
        chk("stall_sync", fft_sync, prev_sync);
      end
      if (fft_valid && first_pending) begin
        chk("first_valid_latency", cyc - start_cyc, RD_LAT + 1);
        first_pending = 1'b0;
      end
      chk("sync_without_valid", fft_sync & ~fft_valid, 0);
      if (rd_en) begin
        chk("rd_addr_order", rd_addr, reads);
        reads++;
      end
      if (fft_valid && fft_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", fft_data, e.data);
          chk("beat_sync", fft_sync, e.sync);
        end
        accepted++;
      end
      if (model_busy) chk("outstanding_le_depth", (reads - accepted) <= DEPTH, 1);
      if (done) begin
        done_count++;
        chk("done_expected", model_busy, 1);
        chk("done_all_sent", exp_q.size(), 0);
        if (time_done) chk("done_latency", cyc - start_cyc, RD_LAT + SAMPLES + 1);
        model_busy = 1'b0;
        done_seen  = 1'b1;
      end
      stall_prev = fft_valid && !fft_ready;
      prev_data  = fft_data;
      prev_sync  = fft_sync;
      stall_gen  = abort_gen;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    if (!model_busy) begin
      model_busy    = 1'b1;
      start_cyc     = cyc + 1;
      reads         = 0;
      accepted      = 0;
      first_pending = 1'b1;
      done_seen     = 1'b0;
      for (int i = 0; i < SAMPLES; i++) begin
        beat_t e;
        e.data = ram[i];
        e.sync = (i == 0);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int k = 0; k < bound && !done_seen; k++) @(negedge clk);
    chk("done_within_bound", done_seen, 1);
  endtask

  task automatic abort_model();
    abort_gen++;
    exp_q.delete();
    model_busy    = 1'b0;
    first_pending = 1'b0;
  endtask

  initial begin
    int dc;
    for (int i = 0; i < SAMPLES; i++) ram[i] = $urandom();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_fft_valid", fft_valid, 0);
    chk("rst_fft_sync", fft_sync, 0);
    chk("rst_fft_data", fft_data, 0);
    rst_n = 1'b1;

    // 1: ready held high, exact latencies
    ready_mode = 0;
    repeat (2) @(posedge clk);
    time_done = 1'b1;
    do_start();
    wait_done(200);
    time_done = 1'b0;
    chk("t1_beats", accepted, SAMPLES);

    // 2: random backpressure
    ready_mode = 1;
    do_start();
    wait_done(600);
    chk("t2_beats", accepted, SAMPLES);

    // 3: ready low for 20 cycles from start
    ready_mode = 2;
    repeat (2) @(posedge clk);
    do_start();
    repeat (20) @(posedge clk);
    #1;
    chk("t3_reads_issued", reads, DEPTH);
    chk("t3_rd_en_held", rd_en, 0);
    ready_mode = 0;
    wait_done(200);
    chk("t3_beats", accepted, SAMPLES);

    // 4: clr at beat 7, then a clean new frame
    do_start();
    for (int k = 0; k < 200 && accepted < 7; k++) @(posedge clk);
    chk("t4_reached_beat7", accepted >= 7, 1);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    abort_model();
    chk("t4_busy_after_clr", busy, 0);
    chk("t4_valid_after_clr", fft_valid, 0);
    dc = done_count;
    repeat (25) @(posedge clk);
    chk("t4_no_done", done_count, dc);
    do_start();
    wait_done(200);
    chk("t4_beats_after_restart", accepted, SAMPLES);

    // 5: start pulsed while busy
    dc = done_count;
    do_start();
    repeat (4) @(posedge clk);
    do_start();
    repeat (9) @(posedge clk);
    do_start();
    wait_done(200);
    repeat (6) @(posedge clk);
    chk("t5_beats", accepted, SAMPLES);
    chk("t5_single_done", done_count, dc + 1);

    // 6: async reset in DRAIN
    ready_mode = 1;
    do_start();
    for (int k = 0; k < 400 && reads < SAMPLES; k++) @(posedge clk);
    #1;
    chk("t6_busy_before_rst", busy, 1);
    #1;
    rst_n = 1'b0;
    abort_model();
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_rd_en", rd_en, 0);
    chk("t6_rst_valid", fft_valid, 0);
    chk("t6_rst_sync", fft_sync, 0);
    chk("t6_rst_data", fft_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_idle_after_rst", busy, 0);
    chk("t6_rd_addr_after_rst", rd_addr, 0);
    ready_mode = 0;
    do_start();
    wait_done(200);
    chk("t6_beats_after_rst", accepted, SAMPLES);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
